fetch_controller: RTL and testbench
===================================

# fetch_controller

Sequencing controller for the instruction-fetch stage of the MIPS-DLX pipeline. It drives the fetch stage's PC write-enable, PC-source select and jump target, and the IF/ID pipeline register's write-enable and flush. It handles post-reset boot bubbles, branch/jump redirects with synchronous-memory flush, load-use stalls, halt and single-step debug. It also keeps saturating stall and redirect counters for performance inspection.

## Interface
- PC_WIDTH, 10: width of PC and jump target.
- BOOT_CYCLES, 2: bubble cycles after reset before the first valid fetch; legal range 1..15.
- CNT_WIDTH, 16: width of each performance counter.

- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_req  in  1  load-use hazard from ID; hold PC and IF/ID.
- redirect_req  in  1  taken branch/jump resolved; load redirect_target.
- redirect_target  in  PC_WIDTH  new PC for the redirect.
- halt_req  in  1  halt instruction decoded in ID.
- resume  in  1  one-cycle pulse; leave HALT.
- step_mode  in  1  1 = single-step debug mode.
- step_req  in  1  one-cycle pulse; allow one fetch in step mode.
- PC_write  out  1  fetch-stage PC enable.
- PC_sel  out  1  0 = PC+1, 1 = jump_address.
- jump_address  out  PC_WIDTH  target presented to the fetch mux.
- IF_ID_write  out  1  IF/ID register enable.
- IF_ID_flush  out  1  insert a bubble into IF/ID.
- halted  out  1  high while in HALT.
- step_ack  out  1  one-cycle pulse after a step fetch is taken.
- stall_count  out  CNT_WIDTH  saturating count of stalled cycles.
- redirect_count  out  CNT_WIDTH  saturating count of accepted redirects.

## Operation
- States: BOOT, RUN, FLUSH, HALT. State is held in a register; outputs are combinational from state and inputs.
- Reset values:
  - state = BOOT, boot counter = 0.
  - PC_write = 0, PC_sel = 0, jump_address = 0, IF_ID_write = 0, IF_ID_flush = 1.
  - halted = 0, step_ack = 0, both counters = 0.
- BOOT: PC_write = 0 and IF_ID_flush = 1. Leave for RUN after BOOT_CYCLES cycles. All requests are ignored.
- RUN: the first matching rule applies.
  - redirect_req: PC_sel = 1, jump_address = redirect_target, PC_write = 1, IF_ID_flush = 1. Go to FLUSH. redirect_count increments.
  - halt_req: PC_write = 0, IF_ID_write = 0. Go to HALT.
  - stall_req: PC_write = 0, IF_ID_write = 0. stall_count increments.
  - step_mode = 1: PC_write = IF_ID_write = step_req. step_ack is registered high the next cycle when step_req was accepted.
  - Otherwise: PC_write = 1, IF_ID_write = 1, PC_sel = 0.
- FLUSH: exists because instruction memory has one cycle of read latency.
  - IF_ID_flush = 1 and PC_write = 1 (sequential fetch from the target). halt_req and stall_req are ignored, since ID holds a bubble. Return to RUN.
  - A redirect_req in FLUSH is accepted as in RUN, stays in FLUSH and counts.
- HALT: PC_write = 0, IF_ID_write = 0, halted = 1. A resume pulse returns to RUN. Only reset_n can leave HALT otherwise.
- jump_address equals redirect_target whenever redirect_req is accepted; otherwise it holds 0.
- Counters saturate at all ones and never wrap.

## Timing
- The fetch stage latches the PC on the falling edge of clock. Controller outputs must settle within the first half-cycle after the rising edge. There is no combinational path from outputs back to inputs.
- Redirect latency: target is written on the falling edge of the request cycle and becomes instruction-memory data two edges later. Two IF/ID bubbles result: the request cycle and FLUSH.
- Stall holds PC and IF/ID for exactly the cycles in which stall_req is high; zero added latency on release.
- Step: one fetch per step_req pulse. step_ack follows 1 cycle later. A step_req during stall is dropped and gets no ack.
- Reset asserted mid-operation: immediate async return to BOOT with all outputs at their reset values. Deassertion is synchronised by the user of this block.

## Structure
- A shared package `fetch_ctrl_pkg` holds:
  - state encoding localparams (BOOT = 0, RUN = 1, FLUSH = 2, HALT = 3);
  - the default PC_WIDTH;
  - the BOOT_CYCLES bound.
- Sub-module `sat_counter` (parameterised width, enable, async active-low clear) is instantiated twice, for stall_count and redirect_count.

## Test plan
- Reset then idle, BOOT_CYCLES = 2 -> IF_ID_flush = 1 for 2 cycles, PC_write rises on cycle 3, then PC advances 0, 1, 2, …
- redirect_req with target 10'h05A in RUN -> PC_sel = 1, jump_address = 10'h05A that cycle; IF_ID_flush high 2 cycles; redirect_count = 1.
- stall_req held 3 cycles together with redirect_req in the 2nd cycle -> redirect wins in that cycle; stall_count = 1 before the redirect, none counted in FLUSH.
- halt_req in RUN -> halted = 1 and PC frozen for 20 cycles; resume pulse -> PC_write = 1 the next cycle; halt_req during FLUSH -> ignored.
- step_mode = 1 with 3 step_req pulses 5 cycles apart -> PC advances exactly 3, three step_ack pulses each 1 cycle late.
- Force stall_count near saturation (CNT_WIDTH = 4, 20 stall cycles) -> stall_count holds at 4'hF. reset_n low mid-FLUSH -> all outputs immediately at reset values.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencing controller.
package fetch_ctrl_pkg;

  // Controller states, encoded BOOT = 0, RUN = 1, FLUSH = 2, HALT = 3.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  // Default width of the PC and of the jump target.
  localparam int PC_WIDTH_DEF = 10;

  // Largest number of post-reset bubble cycles the boot counter can express.
  localparam int BOOT_CYCLES_MAX = 15;

  // Boot counter width, sized to hold BOOT_CYCLES_MAX.
  localparam int BOOT_CNT_W = $clog2(BOOT_CYCLES_MAX + 1);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Increment that sticks at all ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + WIDTH'(1);
  endfunction

  // Count enabled cycles; clear is immediate.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing controller: boot bubbles, redirect flush,
// load-use stall, halt and single-step, plus stall/redirect counters.
// Outputs are decoded combinationally from the state register and the
// current requests so the fetch stage can latch them on the falling edge.
module fetch_controller
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEF,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 stall_req,
  input  logic                 redirect_req,
  input  logic [PC_WIDTH-1:0]  redirect_target,
  input  logic                 halt_req,
  input  logic                 resume,
  input  logic                 step_mode,
  input  logic                 step_req,
  output logic                 PC_write,
  output logic                 PC_sel,
  output logic [PC_WIDTH-1:0]  jump_address,
  output logic                 IF_ID_write,
  output logic                 IF_ID_flush,
  output logic                 halted,
  output logic                 step_ack,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] redirect_count
);

  fetch_state_t          state;
  fetch_state_t          next_state;
  logic [BOOT_CNT_W-1:0] boot_cnt;
  logic                  boot_done;
  logic                  stall_inc;
  logic                  redirect_inc;
  logic                  step_take;

  // Last bubble cycle of the boot sequence.
  assign boot_done = (boot_cnt == BOOT_CNT_W'(BOOT_CYCLES - 1));

  // Decode fetch controls and the next state from state and requests.
  always_comb begin
    next_state   = state;
    PC_write     = 1'b0;
    PC_sel       = 1'b0;
    jump_address = '0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;
    step_take    = 1'b0;
    case (state)
      BOOT: begin
        // Memory output is not yet meaningful; keep bubbles flowing.
        IF_ID_flush = 1'b1;
        if (boot_done) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (redirect_req) begin
          PC_write     = 1'b1;
          PC_sel       = 1'b1;
          jump_address = redirect_target;
          IF_ID_flush  = 1'b1;
          redirect_inc = 1'b1;
          next_state   = FLUSH;
        end else if (halt_req) begin
          next_state = HALT;
        end else if (stall_req) begin
          stall_inc = 1'b1;
        end else if (step_mode) begin
          PC_write    = step_req;
          IF_ID_write = step_req;
          step_take   = step_req;
        end else begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      end
      FLUSH: begin
        // The instruction read at the old PC is still arriving: squash it
        // and keep fetching sequentially from the target. ID holds a bubble,
        // so halt and stall requests cannot be genuine here.
        PC_write    = 1'b1;
        IF_ID_flush = 1'b1;
        if (redirect_req) begin
          PC_sel       = 1'b1;
          jump_address = redirect_target;
          redirect_inc = 1'b1;
        end else begin
          next_state = RUN;
        end
      end
      HALT: begin
        halted = 1'b1;
        if (resume) begin
          next_state = RUN;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  // State, boot bubble counter and the registered step acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      boot_cnt <= '0;
      step_ack <= 1'b0;
    end else begin
      state    <= next_state;
      step_ack <= step_take;
      if (state == BOOT && !boot_done) begin
        boot_cnt <= boot_cnt + BOOT_CNT_W'(1);
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clock   (clock),
    .clear_n (reset_n),
    .en      (stall_inc),
    .count   (stall_count)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_redirect_cnt (
    .clock   (clock),
    .clear_n (reset_n),
    .en      (redirect_inc),
    .count   (redirect_count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small fetch-stage PC model.
module tb_fetch_controller;

  logic       clock;
  logic       reset_n;
  logic       stall_req;
  logic       redirect_req;
  logic [9:0] redirect_target;
  logic       halt_req;
  logic       resume;
  logic       step_mode;
  logic       step_req;
  logic       PC_write;
  logic       PC_sel;
  logic [9:0] jump_address;
  logic       IF_ID_write;
  logic       IF_ID_flush;
  logic       halted;
  logic       step_ack;
  logic [3:0] stall_count;
  logic [3:0] redirect_count;
  logic [9:0] pc_m;

  int n_total = 0;
  int n_pass  = 0;

  fetch_controller #(
    .PC_WIDTH    (10),
    .BOOT_CYCLES (2),
    .CNT_WIDTH   (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .stall_req       (stall_req),
    .redirect_req    (redirect_req),
    .redirect_target (redirect_target),
    .halt_req        (halt_req),
    .resume          (resume),
    .step_mode       (step_mode),
    .step_req        (step_req),
    .PC_write        (PC_write),
    .PC_sel          (PC_sel),
    .jump_address    (jump_address),
    .IF_ID_write     (IF_ID_write),
    .IF_ID_flush     (IF_ID_flush),
    .halted          (halted),
    .step_ack        (step_ack),
    .stall_count     (stall_count),
    .redirect_count  (redirect_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Fetch-stage PC, latched on the falling edge as the real stage does.
  always @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_m <= '0;
    end else if (PC_write) begin
      pc_m <= PC_sel ? jump_address : pc_m + 10'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n         = 1'b1;
    stall_req       = 1'b0;
    redirect_req    = 1'b0;
    redirect_target = '0;
    halt_req        = 1'b0;
    resume          = 1'b0;
    step_mode       = 1'b0;
    step_req        = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_pc_write", PC_write, 0);
    check("rst_pc_sel", PC_sel, 0);
    check("rst_jump", jump_address, 0);
    check("rst_ifid_write", IF_ID_write, 0);
    check("rst_ifid_flush", IF_ID_flush, 1);
    check("rst_halted", halted, 0);
    check("rst_step_ack", step_ack, 0);
    check("rst_stall_cnt", stall_count, 0);
    check("rst_redir_cnt", redirect_count, 0);
    #4 reset_n = 1'b1;
    #1;
    // Boot bubble 1
    check("boot1_flush", IF_ID_flush, 1);
    check("boot1_pc_write", PC_write, 0);
    // Boot bubble 2, redirect must be ignored
    next_cycle();
    redirect_req = 1'b1; redirect_target = 10'h3FF;
    #1;
    check("boot2_flush", IF_ID_flush, 1);
    check("boot2_pc_write", PC_write, 0);
    check("boot2_pc_sel", PC_sel, 0);
    check("boot2_jump", jump_address, 0);
    // First fetch
    next_cycle();
    redirect_req = 1'b0;
    #1;
    check("run_pc_write", PC_write, 1);
    check("run_ifid_write", IF_ID_write, 1);
    check("run_flush", IF_ID_flush, 0);
    check("boot_redir_ignored", redirect_count, 0);
    check("pc0", pc_m, 10'h000);
    next_cycle(); #1;
    check("pc1", pc_m, 10'h001);
    next_cycle(); #1;
    check("pc2", pc_m, 10'h002);
    // Redirect to 0x05A
    next_cycle();
    redirect_req = 1'b1; redirect_target = 10'h05A;
    #1;
    check("redir_pc_sel", PC_sel, 1);
    check("redir_jump", jump_address, 10'h05A);
    check("redir_flush", IF_ID_flush, 1);
    check("redir_pc_write", PC_write, 1);
    // FLUSH: halt and stall ignored
    next_cycle();
    redirect_req = 1'b0; halt_req = 1'b1; stall_req = 1'b1;
    #1;
    check("flush_flush", IF_ID_flush, 1);
    check("flush_pc_write", PC_write, 1);
    check("flush_pc_sel", PC_sel, 0);
    check("flush_jump", jump_address, 0);
    check("redir_cnt1", redirect_count, 1);
    next_cycle();
    halt_req = 1'b0; stall_req = 1'b0;
    #1;
    check("flush_halt_ignored", halted, 0);
    check("flush_stall_ignored", stall_count, 0);
    check("post_flush_flush", IF_ID_flush, 0);
    check("pc_after_redir", pc_m, 10'h05B);
    // Stall, then stall with redirect, then stall in FLUSH
    next_cycle();
    stall_req = 1'b1;
    #1;
    check("stall_pc_write", PC_write, 0);
    check("stall_ifid_write", IF_ID_write, 0);
    next_cycle();
    redirect_req = 1'b1; redirect_target = 10'h123;
    #1;
    check("stall_cnt1", stall_count, 1);
    check("stall_redir_pc_sel", PC_sel, 1);
    check("stall_redir_jump", jump_address, 10'h123);
    check("stall_redir_pc_write", PC_write, 1);
    next_cycle();
    redirect_req = 1'b0;
    #1;
    check("flush_stall_pc_write", PC_write, 1);
    check("redir_cnt2", redirect_count, 2);
    next_cycle();
    stall_req = 1'b0;
    #1;
    check("stall_cnt_no_flush", stall_count, 1);
    check("pc_after_stall", pc_m, 10'h124);
    // Halt
    next_cycle();
    halt_req = 1'b1;
    #1;
    check("halt_req_pc_write", PC_write, 0);
    check("halt_req_ifid_write", IF_ID_write, 0);
    next_cycle();
    halt_req = 1'b0;
    #1;
    check("halted", halted, 1);
    repeat (19) next_cycle();
    check("halt_hold", halted, 1);
    check("halt_pc_frozen", pc_m, 10'h125);
    check("halt_pc_write", PC_write, 0);
    next_cycle();
    redirect_req = 1'b1; redirect_target = 10'h0AA;
    #1;
    check("halt_redir_pc_sel", PC_sel, 0);
    check("halt_redir_pc_write", PC_write, 0);
    next_cycle();
    redirect_req = 1'b0; resume = 1'b1;
    #1;
    check("halt_redir_stay", halted, 1);
    check("halt_redir_cnt", redirect_count, 2);
    check("resume_cycle_pc_write", PC_write, 0);
    next_cycle();
    resume = 1'b0;
    #1;
    check("resume_pc_write", PC_write, 1);
    check("resume_halted", halted, 0);
    // Single-step
    next_cycle();
    step_mode = 1'b1;
    #1;
    check("step_idle_pc_write", PC_write, 0);
    check("step_idle_ifid", IF_ID_write, 0);
    check("step_pc_start", pc_m, 10'h126);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      step_req = 1'b1;
      #1;
      check("step_pc_write", PC_write, 1);
      check("step_ifid_write", IF_ID_write, 1);
      check("step_ack_early", step_ack, 0);
      next_cycle();
      step_req = 1'b0;
      #1;
      check("step_ack", step_ack, 1);
      check("step_gap_pc_write", PC_write, 0);
      repeat (3) next_cycle();
      check("step_ack_once", step_ack, 0);
    end
    check("step_pc_end", pc_m, 10'h129);
    next_cycle();
    stall_req = 1'b1; step_req = 1'b1;
    #1;
    check("step_stall_pc_write", PC_write, 0);
    next_cycle();
    stall_req = 1'b0; step_req = 1'b0;
    #1;
    check("step_stall_no_ack", step_ack, 0);
    check("stall_cnt2", stall_count, 2);
    step_mode = 1'b0;
    // Saturation
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      stall_req = 1'b1;
      #1;
      if (i == 12) check("stall_cnt14", stall_count, 14);
    end
    next_cycle();
    stall_req = 1'b0;
    #1;
    check("stall_sat", stall_count, 4'hF);
    // Redirect, redirect in FLUSH, then reset mid-FLUSH
    next_cycle();
    redirect_req = 1'b1; redirect_target = 10'h200;
    #1;
    check("redir2_pc_sel", PC_sel, 1);
    next_cycle();
    redirect_target = 10'h300;
    #1;
    check("flush_redir_jump", jump_address, 10'h300);
    check("flush_redir_pc_sel", PC_sel, 1);
    check("flush_redir_flush", IF_ID_flush, 1);
    check("redir_cnt3", redirect_count, 3);
    next_cycle();
    redirect_req = 1'b0;
    #1;
    check("flush_stay_flush", IF_ID_flush, 1);
    check("flush_stay_pc_sel", PC_sel, 0);
    check("redir_cnt4", redirect_count, 4);
    check("flush_stay_pc_write", PC_write, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_pc_write", PC_write, 0);
    check("mid_rst_flush", IF_ID_flush, 1);
    check("mid_rst_jump", jump_address, 0);
    check("mid_rst_stall_cnt", stall_count, 0);
    check("mid_rst_redir_cnt", redirect_count, 0);
    check("mid_rst_halted", halted, 0);
    #1 reset_n = 1'b1;
    next_cycle();
    check("reboot_pc_write", PC_write, 0);
    check("reboot_flush", IF_ID_flush, 1);
    next_cycle();
    check("reboot_run", PC_write, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
